// File: rtl/seq_shift_add_multiplier.sv
// Sequential unsigned N x N shift-add multiplier.
// One partial-product add per clock through an N-bit carry-lookahead adder (cin = 0).
// The adder's carry-out and sum are shifted back into the accumulator.
// A start/busy/done handshake frames each operation.
module seq_shift_add_multiplier #(
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int unsigned CW = $clog2(N) + 1;

  typedef enum logic {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     mcand_q, mcand_d;
  logic [N-1:0]     acc_hi_q, acc_hi_d;
  logic [N-1:0]     acc_lo_q, acc_lo_d;
  logic [CW-1:0]    count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2*N-1:0]   product_q, product_d;

  // Carry-lookahead adder: acc_hi + mcand + cin
  logic             cin;
  logic [N-1:0]     gen, prop, sum;
  logic [N:0]       carry;
  logic             cout;
  logic [N:0]       t;
  logic [2*N-1:0]   shifted;

  assign cin  = 1'b0;
  assign gen  = acc_hi_q & mcand_q;
  assign prop = acc_hi_q ^ mcand_q;

  // Each carry is a flat sum-of-products over lower generate/propagate terms
  always_comb begin
    logic c, pp;
    c        = 1'b0;
    pp       = 1'b0;
    carry    = '0;
    carry[0] = cin;
    for (int i = 0; i < int'(N); i++) begin
      c  = gen[i];
      pp = prop[i];
      for (int j = i - 1; j >= 0; j--) begin
        c  = c | (pp & gen[j]);
        pp = pp & prop[j];
      end
      carry[i+1] = c | (pp & cin);
    end
  end

  assign sum  = prop ^ carry[N-1:0];
  assign cout = carry[N];

  // One iteration: optionally add, then shift {t, acc_lo} right by one (cout is kept)
  always_comb begin
    t       = acc_lo_q[0] ? {cout, sum} : {1'b0, acc_hi_q};
    shifted = {t, acc_lo_q[N-1:1]};
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    count_d   = count_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d  = a;
          acc_hi_d = '0;
          acc_lo_d = b;
          count_d  = '0;
          busy_d   = 1'b1;
          state_d  = StRun;
        end
      end
      StRun: begin
        {acc_hi_d, acc_lo_d} = shifted;
        count_d              = count_q + CW'(1);
        if (count_q == CW'(N - 1)) begin
          product_d = shifted;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule
